ft245_tx_arbiter: RTL and testbench

FT245_TX_ARBITER -- requirements
Module: ft245_tx_arbiter

---
 rtl/ft245_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 35 +++
 rtl/ft245_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_ft245_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// ft245_pkg
//   Constants shared by the FT245 TX arbiter and its round-robin picker:
//   FSM state encoding, the burst header base byte and the default burst cap.
//   Also holds a small wrap-around increment helper for the round-robin pointer.
package ft245_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HEADER = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;

   localparam logic [7:0] HDR_BASE          = 8'hA0;
   localparam int         DEFAULT_MAX_BURST = 64;

   // (v + 1) mod n without a divider
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin search: returns the first asserted request at or
//   above ptr, wrapping from N-1 back to 0.
// Ports:
//   req    [N-1:0]   request vector
//   ptr    [PW-1:0]  search start index (0..N-1)
//   winner [N-1:0]   one-hot winning request, zero when none
//   valid            any request asserted
module rr_priority_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  winner,
   output logic          valid
);
   import ft245_pkg::*;

   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter
//   Round-robin arbiter merging NUM_REQ byte streams onto one FT245 TX
//   ready/ack interface. A grant lasts until the granted requester sends its
//   last byte or MAX_BURST bytes have been sent; no preemption in between.
//   Optional: define ARB_HEADER_EN to prefix every burst with one header byte
//   (HDR_BASE | granted index).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_data_si/rdy_si/last_si    per-requester byte, valid, end-of-packet
//   req_ack_si                    per-requester byte consumed
//   tx_data_si/tx_rdy_si          byte and valid towards the FT245 interface
//   tx_ack_si                     FT245 interface consumed the byte
//   grant                         registered one-hot grant, zero when idle
//   busy                          FSM not in IDLE
//
// state     | meaning
// ST_IDLE   | no grant; arbitrate among ready requesters
// ST_HEADER | send burst header byte (ARB_HEADER_EN builds only)
// ST_STREAM | forward granted requester's bytes until last or burst cap
module ft245_tx_arbiter
   import ft245_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int FT245_WIDTH = 8,
   parameter int MAX_BURST   = DEFAULT_MAX_BURST
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ*FT245_WIDTH-1:0] req_data_si,
   input  logic [NUM_REQ-1:0]             req_rdy_si,
   input  logic [NUM_REQ-1:0]             req_last_si,
   output logic [NUM_REQ-1:0]             req_ack_si,
   output logic [FT245_WIDTH-1:0]         tx_data_si,
   output logic                           tx_rdy_si,
   input  logic                           tx_ack_si,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy
);

   localparam int         PW       = $clog2(NUM_REQ);
   localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

   logic [1:0]             state;
   logic [PW-1:0]          g_idx;
   logic [PW-1:0]          rr_ptr;
   logic [PW-1:0]          win_idx;
   logic [PW-1:0]          next_ptr;
   logic [7:0]             burst_cnt;
   logic [NUM_REQ-1:0]     winner;
   logic                   win_valid;
   logic                   g_rdy;
   logic                   g_last;
   logic [FT245_WIDTH-1:0] g_data;
   logic                   xfer;

   rr_priority_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req    (req_rdy_si),
      .ptr    (rr_ptr),
      .winner (winner),
      .valid  (win_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) win_idx = PW'(i);
      end
   end

   assign g_rdy    = req_rdy_si[g_idx];
   assign g_last   = req_last_si[g_idx];
   assign g_data   = req_data_si[int'(g_idx)*FT245_WIDTH +: FT245_WIDTH];
   assign next_ptr = PW'(wrap_inc(int'(g_idx), NUM_REQ));

   always_comb begin
      tx_data_si = '0;
      tx_rdy_si  = 1'b0;
      req_ack_si = '0;
      case (state)
         ST_STREAM: begin
            tx_data_si = g_data;
            tx_rdy_si  = g_rdy;
            req_ack_si = grant & {NUM_REQ{tx_ack_si & g_rdy}};
         end
`ifdef ARB_HEADER_EN
         ST_HEADER: begin
            tx_data_si = FT245_WIDTH'(HDR_BASE | 8'(g_idx));
            tx_rdy_si  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign xfer = tx_rdy_si & tx_ack_si;
   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant     <= '0;
         g_idx     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  grant     <= winner;
                  g_idx     <= win_idx;
                  burst_cnt <= '0;
`ifdef ARB_HEADER_EN
                  state     <= ST_HEADER;
`else
                  state     <= ST_STREAM;
`endif
               end
            end
`ifdef ARB_HEADER_EN
            ST_HEADER: begin
               if (xfer) state <= ST_STREAM;
            end
`endif
            ST_STREAM: begin
               if (xfer) begin
                  burst_cnt <= burst_cnt + 8'd1;
                  // pointer moves past the winner so a waiting peer goes next
                  if (g_last || burst_cnt == LAST_CNT) begin
                     state  <= ST_IDLE;
                     grant  <= '0;
                     rr_ptr <= next_ptr;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
`timescale 1ns/1ps
module tb_ft245_tx_arbiter;
   localparam int NREQ = 3;
   localparam int W    = 8;
`ifdef ARB_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic                clk;
   logic                rst;
   logic [NREQ*W-1:0]   req_data_si;
   logic [NREQ-1:0]     req_rdy_si;
   logic [NREQ-1:0]     req_last_si;
   logic [NREQ-1:0]     req_ack_si;
   logic [W-1:0]        tx_data_si;
   logic                tx_rdy_si;
   logic                tx_ack_si;
   logic [NREQ-1:0]     grant;
   logic                busy;

   ft245_tx_arbiter #(.NUM_REQ(NREQ), .FT245_WIDTH(W), .MAX_BURST(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_data_si (req_data_si),
      .req_rdy_si  (req_rdy_si),
      .req_last_si (req_last_si),
      .req_ack_si  (req_ack_si),
      .tx_data_si  (tx_data_si),
      .tx_rdy_si   (tx_rdy_si),
      .tx_ack_si   (tx_ack_si),
      .grant       (grant),
      .busy        (busy)
   );

   typedef struct packed { logic last; logic [7:0] data; } src_t;
   typedef struct packed { logic hdr; logic [7:0] data; logic [1:0] idx; } exp_t;

   src_t            src_q [NREQ][$];
   logic [NREQ-1:0] en;
   exp_t            exp_q [$];
   int              xfer_cyc [$];
   int              nvec, nbad, data_xfers, cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < NREQ; i++) begin
         if (en[i] && src_q[i].size() > 0) begin
            req_rdy_si[i]          = 1'b1;
            req_data_si[i*W +: W]  = src_q[i][0].data;
            req_last_si[i]         = src_q[i][0].last;
         end else begin
            req_rdy_si[i]          = 1'b0;
            req_data_si[i*W +: W]  = '0;
            req_last_si[i]         = 1'b0;
         end
      end
   endtask

   // requester models: consume a byte after each acked clock edge
   initial begin
      logic [NREQ-1:0] ackv;
      en = '1;
      drive_src();
      forever begin
         @(negedge clk);
         ackv = req_ack_si;
         @(posedge clk);
         #2;
         for (int i = 0; i < NREQ; i++)
            if (ackv[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         drive_src();
      end
   end

   // monitor: every FT245 transfer is popped from the scoreboard and compared
   initial begin
      exp_t            e;
      logic [NREQ-1:0] oh;
      forever begin
         @(negedge clk);
         if (tx_rdy_si && tx_ack_si) begin
            nvec++;
            if (exp_q.size() == 0) begin
               nbad++;
               $display("FAIL unexpected_xfer: got data %0h grant %0b, required no transfer",
                        tx_data_si, grant);
            end else begin
               e  = exp_q.pop_front();
               oh = NREQ'(1) << e.idx;
               if (tx_data_si !== e.data || grant !== oh ||
                   req_ack_si !== (e.hdr ? '0 : oh)) begin
                  nbad++;
                  $display("FAIL xfer: got data %0h grant %0b ack %0b, required data %0h grant %0b ack %0b",
                           tx_data_si, grant, req_ack_si, e.data, oh, (e.hdr ? '0 : oh));
               end
               if (!e.hdr) begin
                  data_xfers++;
                  xfer_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   task automatic load_seq(input int r, input logic [7:0] start, input logic [7:0] step,
                           input int n, input logic last_end);
      logic [7:0] d;
      d = start;
      for (int k = 0; k < n; k++) begin
         src_q[r].push_back({(last_end && k == n-1), d});
         d = d + step;
      end
   endtask

   // one expected burst of requester r (with its header byte in header builds)
   task automatic expect_seq(input int r, input logic [7:0] start, input logic [7:0] step,
                             input int n);
      logic [7:0] d;
      d = start;
`ifdef ARB_HEADER_EN
      exp_q.push_back({1'b1, 8'hA0 | 8'(r), 2'(r)});
`endif
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({1'b0, d, 2'(r)});
         d = d + step;
      end
   endtask

   task automatic wait_data(input int n, input int budget);
      int c;
      c = 0;
      while (data_xfers < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      if (data_xfers < n) begin
         nvec++;
         nbad++;
         $display("FAIL wait_data: got %0d transfers, required %0d", data_xfers, n);
      end
   endtask

   initial begin
      int base, k0, per;
      nvec = 0; nbad = 0; data_xfers = 0;
      rst = 1'b1;
      tx_ack_si = 1'b0;
      per = HDR + 3;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_tx_rdy", tx_rdy_si, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_ack", req_ack_si, 0);
      chk("rst_tx_data", tx_data_si, 0);

      // single requester 0: 0x11,0x22,0x33
      @(posedge clk); #1;
      tx_ack_si = 1'b1;
      base = data_xfers;
      load_seq(0, 8'h11, 8'h11, 3, 1'b1);
      expect_seq(0, 8'h11, 8'h11, 3);
      @(negedge clk);
      chk("arb_cycle_busy", busy, 0);
      chk("arb_cycle_tx_rdy", tx_rdy_si, 0);
      @(negedge clk);
      chk("lat_tx_rdy", tx_rdy_si, 1);
      chk("lat_grant", grant, 3'b001);
      chk("lat_tx_data", tx_data_si, HDR ? 8'hA0 : 8'h11);
      wait_data(base + 3, 20);
      @(negedge clk);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_data", tx_data_si, 0);
      chk("t1_rr_ptr", dut.rr_ptr, 1);

      // three requesters, 2-byte packets: order 0,1,2,0 with one idle cycle between
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      base = data_xfers;
      k0 = cyc;
      xfer_cyc.delete();
      load_seq(0, 8'h01, 8'h01, 2, 1'b1);
      load_seq(0, 8'h03, 8'h01, 2, 1'b1);
      load_seq(1, 8'h21, 8'h01, 2, 1'b1);
      load_seq(2, 8'h31, 8'h01, 2, 1'b1);
      expect_seq(0, 8'h01, 8'h01, 2);
      expect_seq(1, 8'h21, 8'h01, 2);
      expect_seq(2, 8'h31, 8'h01, 2);
      expect_seq(0, 8'h03, 8'h01, 2);
      wait_data(base + 8, 80);
      chk("rr_xfer_count", xfer_cyc.size(), 8);
      for (int j = 0; j < xfer_cyc.size(); j++)
         chk($sformatf("rr_timing_%0d", j), xfer_cyc[j] - k0, (j/2)*per + HDR + 1 + (j%2));

      // requester 1 streams 100 bytes with requester 2 waiting: 64, then 2 of r2, then 36
      @(posedge clk); #1;
      base = data_xfers;
      load_seq(1, 8'h00, 8'h01, 100, 1'b1);
      load_seq(2, 8'hC0, 8'h01, 2, 1'b1);
      expect_seq(1, 8'h00, 8'h01, 64);
      expect_seq(2, 8'hC0, 8'h01, 2);
      expect_seq(1, 8'h40, 8'h01, 36);
      wait_data(base + 102, 400);
      @(negedge clk);
      chk("burst_idle_busy", busy, 0);

      // stall: tx_ack low 5 cycles, then requester rdy low 3 cycles
      @(posedge clk); #1;
      base = data_xfers;
      load_seq(0, 8'h61, 8'h01, 6, 1'b1);
      expect_seq(0, 8'h61, 8'h01, 6);
      wait_data(base + 2, 20);
      #1 tx_ack_si = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_ack", req_ack_si, 0);
         chk("stall_grant", grant, 3'b001);
         chk("stall_tx_rdy", tx_rdy_si, 1);
      end
      @(posedge clk); #1;
      tx_ack_si = 1'b1;
      en[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("norq_tx_rdy", tx_rdy_si, 0);
         chk("norq_ack", req_ack_si, 0);
         chk("norq_grant", grant, 3'b001);
         chk("norq_busy", busy, 1);
      end
      @(posedge clk); #1;
      en[0] = 1'b1;
      wait_data(base + 6, 30);

      // reset during byte 2 of a 4-byte burst from requester 1
      @(posedge clk); #1;
      base = data_xfers;
      load_seq(1, 8'h91, 8'h01, 4, 1'b1);
      expect_seq(1, 8'h91, 8'h01, 2);
      wait_data(base + 1, 20);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      src_q[1].delete();
      @(negedge clk);
      chk("mid_rst_tx_rdy", tx_rdy_si, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_grant", grant, 0);
      @(posedge clk); #1;
      base = data_xfers;
      load_seq(0, 8'hB1, 8'h01, 1, 1'b1);
      load_seq(1, 8'hB2, 8'h01, 1, 1'b1);
      expect_seq(0, 8'hB1, 8'h01, 1);
      expect_seq(1, 8'hB2, 8'h01, 1);
      wait_data(base + 2, 30);

      // requester 2 single byte 0x55 (preceded by 0xA2 in header builds)
      @(posedge clk); #1;
      base = data_xfers;
      load_seq(2, 8'h55, 8'h01, 1, 1'b1);
      expect_seq(2, 8'h55, 8'h01, 1);
      wait_data(base + 1, 20);

      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("end_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
